aes128_keyexp_engine: RTL
=========================

# aes128_keyexp_engine

Hardware AES-128 key-expansion engine that sits beside the AES data memory and shares its single port. On `start` it reads the 128-bit initial key and the ten round constants from data memory, computes the 40 round-key words w[4..43] per FIPS-197, and writes them back into the round-key region. The RV32IM core then only runs the round datapath over precomputed keys. A top-level mux gives this block the memory port while `busy` is high.

## Interface
Parameters:
- `KEY_BASE`, 32'h0000_0048, byte address of initial key word w[0] (word index 0x12).
- `RCON_BASE`, 32'h0000_0000, byte address of Rcon[1] (word index 0x00).
- `RK_BASE`, 32'h0000_0058, byte address of w[4] (word index 0x16); 40 consecutive words, ending at word 0x3d.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `busy`  out  1  high while the engine owns the memory port.
- `done`  out  1  one-cycle completion pulse.
- `addr`  out  32  word-aligned byte address to data memory.
- `we`  out  4  write strobe to data memory: 4'b1111 on writes, else 4'b0000.
- `datain`  out  32  write data to data memory.
- `dataout`  in  32  combinational read data from data memory for the current `addr`.

## Operation
- Word byte order: byte0 = bits[7:0] (RISC-V little-endian). Rcon occupies bits[7:0].
- RotWord(w) = {w[7:0], w[31:8]}. SubWord applies the AES S-box to each byte.
- Key window registers k0..k3 (k0 oldest), Rcon register `rc`, round counter r (1..10), word counter j (0..3).
- FSM states:
  - IDLE: `start` -> LOAD, with j=0.
  - LOAD: addr=KEY_BASE+4j, and kj<=dataout. After j=3 -> RCON, with r=1.
  - RCON: addr=RCON_BASE+4(r-1), and rc<=dataout -> WRITE, with j=0.
  - WRITE: new = k0 ^ (j==0 ? SubWord(RotWord(k3))^rc : k3). Drive addr=RK_BASE+16(r-1)+4j, we=4'b1111, datain=new, then shift k0<=k1, k1<=k2, k2<=k3, k3<=new. After j=3: if r==10 -> DONE, else r++ -> RCON.
  - DONE: done=1 for one cycle -> IDLE.
- Outside LOAD/RCON/WRITE: addr=0, we=0, datain=0.
- `start` while not IDLE is ignored; no queuing.
- `rst` at any time, including mid-expansion, forces IDLE and clears k0..k3, rc, r and j. Round keys already written stay in memory; the remaining round keys are not written.

## Timing
- Reset values: busy=0, done=0, addr=0, we=0, datain=0.
- `start` high in cycle 0 (IDLE) gives: LOAD in cycles 1-4; then for each round r, RCON in cycle 5r and WRITE in cycles 5r+1..5r+4.
- The last write is in cycle 54. `done` is high in cycle 55. IDLE again in cycle 56, where a new `start` is accepted.
- `busy` is high exactly in cycles 1-54.
- Memory read is combinational: the engine captures `dataout` on the same edge that ends the address cycle.
- Each write is a single-cycle full-word write. Exactly 40 write cycles per run, with strictly increasing addresses.
- addr, we and datain are combinational decodes of state and counters, so they are glitch-free at the clock edge.

## Structure
- Shared package `aes128_pkg`: state encoding, default base addresses, function `rotword`.
- Sub-module `aes_sbox` (256-entry combinational byte S-box), instantiated 4x for SubWord. It is reused later by the round datapath.

## Test plan
- FIPS-197 A.1 key loaded as w0..w3 = 16157e2b, a6d2ae28, 8815f7ab, 3c4fcf09 -> memory word 0x16 = 17fefaa0, word 0x3a = a8f914d0, word 0x3d = a60c63b6.
- Protocol, with `start` in cycle 0 -> busy high cycles 1-54, exactly 40 cycles with we=4'b1111, done a single pulse in cycle 55, all outputs 0 in IDLE.
- Address trace -> cycles 1-4 addr 0x48..0x54, cycle 5 addr 0x00, cycles 6-9 addr 0x58..0x64, cycle 54 addr 0xf4.
- `start` pulsed in cycle 20 -> ignored. Result identical to a single run, with done only in cycle 55.
- `rst` asserted in cycle 30 -> next cycle busy=0 and we=0. Words 0x16..0x29 hold correct values; 0x2a..0x3d remain 0. A fresh `start` completes correctly.
- All-zero key with back-to-back runs (`start` in cycle 56) -> word 0x16 = 63636362, and the second run produces identical memory.

Source files
------------

// File: rtl/aes128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes128_pkg
// Description : Shared types, default base addresses and word helpers for the
//               AES-128 key-expansion engine.
// Revision    : 1.0
// ============================================================================
package aes128_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RCON  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] C_KEY_BASE  = 32'h0000_0048;
    localparam logic [31:0] C_RCON_BASE = 32'h0000_0000;
    localparam logic [31:0] C_RK_BASE   = 32'h0000_0058;
    localparam logic [3:0]  C_LAST_ROUND = 4'd10;

    // Byte0 lives in bits[7:0], so a left byte-rotate is a right shift.
    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[7:0], w[31:8]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes128_keyexp_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : aes128_keyexp_engine_if
// Description : Control handshake and shared data-memory port of the
//               key-expansion engine.
// Revision    : 1.0
// ============================================================================
interface aes128_keyexp_engine_if;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] datain;
    logic [31:0] dataout;

    modport master (
        output start,
        input  busy,
        input  done,
        input  addr,
        input  we,
        input  datain,
        output dataout
    );

    modport slave (
        input  start,
        output busy,
        output done,
        output addr,
        output we,
        output datain,
        input  dataout
    );
endinterface
`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// Module      : aes_sbox
// Description : Combinational AES forward S-box, one byte in, one byte out.
// Revision    : 1.0
// ============================================================================
module aes_sbox (
    input  wire logic [7:0] i_byte,
    output logic      [7:0] o_byte
);
    localparam logic [7:0] C_SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = C_SBOX[i_byte];
endmodule
`default_nettype wire

// File: rtl/aes128_keyexp_engine.sv
`default_nettype none
// ============================================================================
// Module      : aes128_keyexp_engine
// Description : Reads the AES-128 key and Rcon table from data memory and
//               writes back round-key words w[4..43] through a shared port.
// Revision    : 1.0
// ============================================================================
module aes128_keyexp_engine
    import aes128_pkg::*;
#(
    parameter logic [31:0] KEY_BASE  = C_KEY_BASE,
    parameter logic [31:0] RCON_BASE = C_RCON_BASE,
    parameter logic [31:0] RK_BASE   = C_RK_BASE
) (
    input  wire logic              clk,
    input  wire logic              rst,
    aes128_keyexp_engine_if.slave  bus
);
    state_t      r_state;
    logic [31:0] r_k0, r_k1, r_k2, r_k3;
    logic [7:0]  r_rc;
    logic [3:0]  r_round;
    logic [1:0]  r_j;
    logic        r_busy;
    logic        r_done;

    logic [31:0] w_rot;
    logic [31:0] w_sub;
    logic [31:0] w_new;
    logic [3:0]  w_rm1;
    logic [31:0] w_addr;
    logic [3:0]  w_we;
    logic [31:0] w_datain;

    assign w_rot = rotword(r_k3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    // First word of each round takes the SubWord/RotWord/Rcon path.
    assign w_new = r_k0 ^ ((r_j == 2'd0) ? (w_sub ^ {24'h0, r_rc}) : r_k3);
    assign w_rm1 = r_round - 4'd1;

    always_comb begin
        w_addr   = 32'h0;
        w_we     = 4'h0;
        w_datain = 32'h0;
        case (r_state)
            ST_LOAD:  w_addr = KEY_BASE + {28'h0, r_j, 2'b00};
            ST_RCON:  w_addr = RCON_BASE + {26'h0, w_rm1, 2'b00};
            ST_WRITE: begin
                w_addr   = RK_BASE + {24'h0, w_rm1, r_j, 2'b00};
                w_we     = 4'hf;
                w_datain = w_new;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_k0    <= 32'h0;
            r_k1    <= 32'h0;
            r_k2    <= 32'h0;
            r_k3    <= 32'h0;
            r_rc    <= 8'h0;
            r_round <= 4'd0;
            r_j     <= 2'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_LOAD;
                        r_j     <= 2'd0;
                        r_busy  <= 1'b1;
                    end
                end
                // Shifting the key in lands w[0] in k0 after four reads.
                ST_LOAD: begin
                    r_k0 <= r_k1;
                    r_k1 <= r_k2;
                    r_k2 <= r_k3;
                    r_k3 <= bus.dataout;
                    r_j  <= r_j + 2'd1;
                    if (r_j == 2'd3) begin
                        r_state <= ST_RCON;
                        r_round <= 4'd1;
                    end
                end
                ST_RCON: begin
                    r_rc    <= bus.dataout[7:0];
                    r_j     <= 2'd0;
                    r_state <= ST_WRITE;
                end
                ST_WRITE: begin
                    r_k0 <= r_k1;
                    r_k1 <= r_k2;
                    r_k2 <= r_k3;
                    r_k3 <= w_new;
                    r_j  <= r_j + 2'd1;
                    if (r_j == 2'd3) begin
                        if (r_round == C_LAST_ROUND) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_round <= r_round + 4'd1;
                            r_state <= ST_RCON;
                        end
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.addr   = w_addr;
    assign bus.we     = w_we;
    assign bus.datain = w_datain;
endmodule
`default_nettype wire
